// File: rtl/cpumem_seq_if.sv
// rtl/cpumem_seq_if.sv - memory controller req/ack port bundle for cpumem_seq
interface cpumem_seq_if #(
    parameter int AW = 16
);
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic          mem_ack;
    logic [7:0]    mem_rdata;

    modport master (
        output mem_req, mem_addr, mem_wdata, mem_we,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, mem_wdata, mem_we,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/cpumem_seq.sv
// rtl/cpumem_seq.sv - one CPU bus access per cputick, completion reported on memdone
// Optional request abort after TIMEOUT busy cycles when CPUMEM_TIMEOUT_EN is defined.
module cpumem_seq #(
    parameter int AW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cputick,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    input  logic          cpu_we,
    output logic [7:0]    cpu_rdata,
    output logic          memdone,
    cpumem_seq_if.master  mem,
    output logic          err_overlap,
    output logic          err_timeout
);
    typedef enum logic {IDLE, BUSY} state_t;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("cpumem_seq: TIMEOUT must be at least 1");
    end

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          done_q, done_d;
    logic          ovl_q, ovl_d;
    logic          tmo_q, tmo_d;

`ifdef CPUMEM_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // Last value seen on the data bus; returned to the CPU when a read is aborted.
    logic [7:0]    latch_q, latch_d;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        done_d  = done_q;
        ovl_d   = ovl_q;
        tmo_d   = 1'b0;
`ifdef CPUMEM_TIMEOUT_EN
        cnt_d   = cnt_q;
        latch_d = latch_q;
`endif
        case (state_q)
            IDLE: begin
                if (cputick) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    we_d    = cpu_we;
                    req_d   = 1'b1;
                    done_d  = 1'b0;
                    state_d = BUSY;
`ifdef CPUMEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                if (cputick) ovl_d = 1'b1;
                if (mem_ack_in()) begin
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    if (!we_q) rdata_d = mem.mem_rdata;
`ifdef CPUMEM_TIMEOUT_EN
                    latch_d = we_q ? wdata_q : mem.mem_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                    if (!we_q) rdata_d = latch_q;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    function automatic logic mem_ack_in();
        return mem.mem_ack;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'h00;
            we_q    <= 1'b0;
            rdata_q <= 8'h00;
            done_q  <= 1'b1;
            ovl_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            ovl_q   <= ovl_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef CPUMEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            latch_q <= 8'h00;
        end else begin
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
        end
    end
`endif

    assign mem.mem_req   = req_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_we    = we_q;
    assign cpu_rdata     = rdata_q;
    assign memdone       = done_q;
    assign err_overlap   = ovl_q;
    assign err_timeout   = tmo_q;
endmodule

// File: tb/tb_cpumem_seq.sv
// tb/tb_cpumem_seq.sv - directed self-checking bench for cpumem_seq
module tb_cpumem_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cputick;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic [7:0]  cpu_rdata;
    logic        memdone;
    logic        err_overlap;
    logic        err_timeout;

    int checks   = 0;
    int failures = 0;

    cpumem_seq_if #(.AW(16)) bus ();

    cpumem_seq #(.AW(16), .TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cputick     (cputick),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_we      (cpu_we),
        .cpu_rdata   (cpu_rdata),
        .memdone     (memdone),
        .mem         (bus.master),
        .err_overlap (err_overlap),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [7:0] d, input logic w);
        cputick   = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = w;
        step();
        cputick   = 1'b0;
    endtask

    task automatic ack(input logic [7:0] d);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = d;
        step();
        bus.mem_ack   = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        cputick       = 1'b0;
        cpu_addr      = 16'h0000;
        cpu_wdata     = 8'h00;
        cpu_we        = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        step();
        step();
        rst_n = 1'b1;
        step();

        chk("rst_memdone", 32'(memdone), 32'h1);
        chk("rst_req", 32'(bus.mem_req), 32'h0);
        chk("rst_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_rdata", 32'(cpu_rdata), 32'h0);
        chk("rst_ovl", 32'(err_overlap), 32'h0);
        chk("rst_tmo", 32'(err_timeout), 32'h0);

        // Read with ack three cycles after the tick
        issue(16'h8000, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("rd_req_hi", 32'(bus.mem_req), 32'h1);
            chk("rd_busy", 32'(memdone), 32'h0);
            chk("rd_addr", 32'(bus.mem_addr), 32'h8000);
            if (i < 2) step();
        end
        ack(8'hA9);
        chk("rd_done", 32'(memdone), 32'h1);
        chk("rd_req_lo", 32'(bus.mem_req), 32'h0);
        chk("rd_data", 32'(cpu_rdata), 32'hA9);
        chk("rd_addr_hold", 32'(bus.mem_addr), 32'h8000);

        // Write leaves cpu_rdata alone
        issue(16'h0010, 8'h5C, 1'b1);
        chk("wr_we", 32'(bus.mem_we), 32'h1);
        chk("wr_wdata", 32'(bus.mem_wdata), 32'h5C);
        ack(8'hFF);
        chk("wr_done", 32'(memdone), 32'h1);
        chk("wr_rdata_hold", 32'(cpu_rdata), 32'hA9);

`ifdef CPUMEM_TIMEOUT_EN
        issue(16'h0020, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("to_busy", 32'(memdone), 32'h0);
            chk("to_no_pulse", 32'(err_timeout), 32'h0);
            step();
        end
        chk("to_done", 32'(memdone), 32'h1);
        chk("to_req_lo", 32'(bus.mem_req), 32'h0);
        chk("to_pulse", 32'(err_timeout), 32'h1);
        chk("to_openbus", 32'(cpu_rdata), 32'h5C);
        step();
        chk("to_pulse_end", 32'(err_timeout), 32'h0);
`else
        issue(16'h0020, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) step();
        chk("nto_wait", 32'(memdone), 32'h0);
        chk("nto_no_pulse", 32'(err_timeout), 32'h0);
        ack(8'h33);
        chk("nto_data", 32'(cpu_rdata), 32'h33);
`endif

        // Overlapping tick, then tick coinciding with ack
        issue(16'h1234, 8'h00, 1'b0);
        chk("ov_clear", 32'(err_overlap), 32'h0);
        issue(16'h0001, 8'h00, 1'b0);
        chk("ov_addr", 32'(bus.mem_addr), 32'h1234);
        chk("ov_flag", 32'(err_overlap), 32'h1);
        chk("ov_req", 32'(bus.mem_req), 32'h1);
        cputick      = 1'b1;
        cpu_addr     = 16'h0002;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'h7E;
        step();
        cputick      = 1'b0;
        bus.mem_ack   = 1'b0;
        chk("ovack_done", 32'(memdone), 32'h1);
        chk("ovack_data", 32'(cpu_rdata), 32'h7E);
        chk("ovack_addr", 32'(bus.mem_addr), 32'h1234);
        step();
        chk("ovack_idle", 32'(memdone), 32'h1);
        chk("ov_sticky", 32'(err_overlap), 32'h1);

        // Back-to-back: memdone high for exactly one cycle
        issue(16'h4000, 8'h00, 1'b0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'h11;
        step();
        bus.mem_ack   = 1'b0;
        chk("b2b_gap_done", 32'(memdone), 32'h1);
        chk("b2b_gap_req", 32'(bus.mem_req), 32'h0);
        issue(16'h4001, 8'h00, 1'b0);
        chk("b2b_busy", 32'(memdone), 32'h0);
        chk("b2b_req", 32'(bus.mem_req), 32'h1);
        chk("b2b_addr", 32'(bus.mem_addr), 32'h4001);
        chk("b2b_rdata", 32'(cpu_rdata), 32'h11);

        // Async reset mid-BUSY, then a stray ack
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_done", 32'(memdone), 32'h1);
        chk("ar_req", 32'(bus.mem_req), 32'h0);
        chk("ar_rdata", 32'(cpu_rdata), 32'h0);
        chk("ar_ovl", 32'(err_overlap), 32'h0);
        step();
        rst_n = 1'b1;
        ack(8'hEE);
        chk("stray_done", 32'(memdone), 32'h1);
        chk("stray_rdata", 32'(cpu_rdata), 32'h0);
        chk("stray_req", 32'(bus.mem_req), 32'h0);
        step();
        chk("stray_idle", 32'(memdone), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
